// File: rtl/eth_axil_reg_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | eth_axil_reg_arbiter: round-robin share of one AXI4-Lite register slave
// | between two single-beat requesters; ETH_ARB_ADDR_CHECK_EN enables range check.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module eth_axil_reg_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_write,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

`ifdef ETH_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_R = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  logic                    w_gnt;
  logic [ADDR_WIDTH-3:0]   w_sel_addr;
  logic                    w_oob;
  logic                    w_unused;

  // Byte-lane bits and the OKAY/EXOKAY distinction carry no information here.
  assign w_unused = ^{req_addr[1:0], req_addr[ADDR_WIDTH+1:ADDR_WIDTH],
                      M_AXI_BRESP[0], M_AXI_RRESP[0]};

  assign w_gnt      = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  assign w_sel_addr = w_gnt ? req_addr[ADDR_WIDTH+2 +: ADDR_WIDTH-2]
                            : req_addr[2 +: ADDR_WIDTH-2];
  assign w_oob      = ADDR_CHECK && (32'(w_sel_addr) >= 32'(NUM_REGS));

  assign M_AXI_AWADDR = {addr_q, 2'b00};
  assign M_AXI_ARADDR = {addr_q, 2'b00};
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = '1;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // Accept pulse is suppressed while reset is held so outputs read all-zero.
          req_ready[w_gnt] = ~ARESET;
          grant_d   = w_gnt;
          write_d   = req_write[w_gnt];
          addr_d    = w_sel_addr;
          wdata_d   = w_gnt ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (w_oob) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = req_write[w_gnt] ? WR : RD_A;
          end
        end
      end
      WR: begin
        M_AXI_AWVALID = ~aw_done_q;
        M_AXI_WVALID  = ~w_done_q;
        aw_done_d     = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
        w_done_d      = w_done_q | (M_AXI_WVALID & M_AXI_WREADY);
        if (aw_done_d && w_done_d) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          err_d   = M_AXI_BRESP[1];
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RD_A: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = RD_R;
        end
      end
      RD_R: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          err_d   = M_AXI_RRESP[1];
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rsp_rdata          = rdata_q;
        rsp_err            = err_q;
        last_grant_d       = grant_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  // write_q is kept for debug visibility of the in-flight transaction type.
  logic w_unused_write;
  assign w_unused_write = write_q;

endmodule
`default_nettype wire
